// File: rtl/cmn_rr_arb_pld.sv
// Round-robin arbiter feeding a one-hot payload mux into a 1-entry output register stage.
// Latency 1 cycle request-to-output; full throughput; v_req_rdy drops while the held entry is stalled.

module cmn_onehot_mux #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic [N-1:0] sel,
  input  logic [W-1:0] din [N],
  output logic [W-1:0] dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      dout = dout | (din[i] & {W{sel[i]}});
    end
  end
endmodule

module cmn_rr_arb_pld #(
  parameter int WIDTH     = 4,
  parameter int PLD_WIDTH = 32,
  parameter int IDX_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     v_req_vld,
  output logic [WIDTH-1:0]     v_req_rdy,
  input  logic [PLD_WIDTH-1:0] v_req_pld [WIDTH],
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [PLD_WIDTH-1:0] out_pld,
  output logic [WIDTH-1:0]     out_sel_onehot,
  output logic [IDX_WIDTH-1:0] out_idx
);
  logic [IDX_WIDTH-1:0] ptr;
  logic [IDX_WIDTH-1:0] ptr_nxt;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic [WIDTH-1:0]     grant;
  logic [PLD_WIDTH-1:0] mux_pld;
  logic                 load_en;
  logic                 xfer;

  assign load_en = ~out_vld | out_rdy;

  // Walk requesters starting at ptr; the index wraps by compare so non-power-of-2 WIDTH works.
  always_comb begin : rr_search
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (!found && v_req_vld[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_WIDTH'(idx);
        found      = 1'b1;
      end
    end
  end

  assign v_req_rdy = grant & {WIDTH{load_en}};
  assign xfer      = |v_req_rdy;
  assign ptr_nxt   = (grant_idx == IDX_WIDTH'(WIDTH - 1)) ? '0 : grant_idx + IDX_WIDTH'(1);

  cmn_onehot_mux #(
    .N (WIDTH),
    .W (PLD_WIDTH)
  ) u_pld_mux (
    .sel  (grant),
    .din  (v_req_pld),
    .dout (mux_pld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld        <= 1'b0;
      out_pld        <= '0;
      out_sel_onehot <= '0;
      out_idx        <= '0;
      ptr            <= '0;
    end else if (xfer) begin
      out_vld        <= 1'b1;
      out_pld        <= mux_pld;
      out_sel_onehot <= grant;
      out_idx        <= grant_idx;
      ptr            <= ptr_nxt;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cmn_rr_arb_pld.sv
// Directed bench for cmn_rr_arb_pld: vector table plus reset, stall and WIDTH=3 sequences.
module tb_cmn_rr_arb_pld;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  vld, rdy, oh;
  logic [31:0] pld [4];
  logic        ovld, ordy;
  logic [31:0] opld;
  logic [1:0]  idx;

  logic [2:0]  vld3, rdy3, oh3;
  logic [7:0]  pld3 [3];
  logic        ovld3, ordy3;
  logic [7:0]  opld3;
  logic [1:0]  idx3;

  int n_pass = 0;
  int n_tot  = 0;

  cmn_rr_arb_pld #(.WIDTH(4), .PLD_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .v_req_vld(vld), .v_req_rdy(rdy), .v_req_pld(pld),
    .out_vld(ovld), .out_rdy(ordy), .out_pld(opld), .out_sel_onehot(oh), .out_idx(idx)
  );

  cmn_rr_arb_pld #(.WIDTH(3), .PLD_WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .v_req_vld(vld3), .v_req_rdy(rdy3), .v_req_pld(pld3),
    .out_vld(ovld3), .out_rdy(ordy3), .out_pld(opld3), .out_sel_onehot(oh3), .out_idx(idx3)
  );

  typedef struct {
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ovld;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // One cycle: drive at negedge, check ready before the edge, check outputs after it.
  task automatic step(input logic [3:0] v, input logic r, input logic [3:0] er,
                      input logic eov, input logic [1:0] ei, input string tag);
    @(negedge clk);
    vld  = v;
    ordy = r;
    #1 chk({tag, " v_req_rdy"}, 32'(rdy), 32'(er));
    @(posedge clk);
    #1;
    chk({tag, " out_vld"}, 32'(ovld), 32'(eov));
    chk({tag, " out_idx"}, 32'(idx), 32'(ei));
    chk({tag, " out_sel_onehot"}, 32'(oh), 32'(4'b0001 << ei));
    chk({tag, " out_pld"}, opld, 32'hA5A5_0000 | 32'(ei));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) pld[i] = 32'hA5A5_0000 | i;
    for (int i = 0; i < 3; i++) pld3[i] = 8'h30 + 8'(i);
    vld = '0; ordy = 1'b1; vld3 = '0; ordy3 = 1'b1;
    rst_n = 1'b0;

    // vld, out_rdy, expected rdy, expected out_vld, expected idx
    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
    tbl[4]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};
    tbl[7]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3};
    tbl[8]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3};
    tbl[9]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

    #22;
    chk("reset out_vld", 32'(ovld), 32'd0);
    chk("reset out_pld", opld, 32'd0);
    chk("reset out_sel_onehot", 32'(oh), 32'd0);
    chk("reset out_idx", 32'(idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].vld, tbl[i].ordy, tbl[i].exp_rdy, tbl[i].exp_ovld, tbl[i].exp_idx,
           $sformatf("vec%0d", i));
    end
    chk("ptr after table", 32'(dut.ptr), 32'd1);

    // Fairness from reset: all requesters valid, no back-pressure.
    @(negedge clk);
    rst_n = 1'b0;
    vld   = '0;
    #1 chk("ptr in reset", 32'(dut.ptr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(4'hF, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), $sformatf("fair%0d", k));
    end

    // Stall with entry idx 3 held, then release: next requester loads with no bubble.
    for (int k = 0; k < 5; k++) begin
      step(4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, $sformatf("stall%0d", k));
    end
    step(4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, "unstall0");
    step(4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, "unstall1");
    chk("ptr before async reset", 32'(dut.ptr), 32'd2);

    // Asynchronous reset mid-cycle with a valid entry held.
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_vld", 32'(ovld), 32'd0);
    chk("async rst out_pld", opld, 32'd0);
    chk("async rst out_idx", 32'(idx), 32'd0);
    chk("async rst out_sel_onehot", 32'(oh), 32'd0);
    chk("async rst ptr", 32'(dut.ptr), 32'd0);
    vld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, "post_rst");

    // WIDTH=3 instance: pointer must wrap 2 -> 0.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vld3 = 3'b111;
      #1 chk($sformatf("w3 rdy%0d", k), 32'(rdy3), 32'(1 << (k % 3)));
      @(posedge clk);
      #1;
      chk($sformatf("w3 out_vld%0d", k), 32'(ovld3), 32'd1);
      chk($sformatf("w3 out_idx%0d", k), 32'(idx3), 32'(k % 3));
      chk($sformatf("w3 out_pld%0d", k), 32'(opld3), 32'(8'h30 + 8'(k % 3)));
      chk($sformatf("w3 ptr%0d", k), 32'(dut3.ptr), 32'((k + 1) % 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/cmn_rr_arb_pld.md
# cmn_rr_arb_pld

Round-robin arbiter with a registered output stage that selects one of `WIDTH` valid/ready requesters and forwards its payload downstream. It sits directly upstream of the shared one-hot payload mux. It produces the one-hot grant that the mux consumes, instantiates that mux internally for the data path, and registers the selected payload, grant and index. The output is a 1-entry pipeline buffer that supports full throughput and accepts back-pressure.

## Interface
- `WIDTH`, 4: number of requesters; must be at least 2.
- `PLD_WIDTH`, 32: payload width in bits.
- `IDX_WIDTH`, `$clog2(WIDTH)`: width of the granted index.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `v_req_vld`  in  `WIDTH`  per-requester valid.
- `v_req_rdy`  out  `WIDTH`  per-requester ready; one-hot or zero.
- `v_req_pld`  in  `WIDTH` x `PLD_WIDTH`  per-requester payload (unpacked array, index = requester).
- `out_vld`  out  1  output entry valid.
- `out_rdy`  in  1  downstream ready.
- `out_pld`  out  `PLD_WIDTH`  registered payload of the granted requester.
- `out_sel_onehot`  out  `WIDTH`  registered one-hot grant of the held entry.
- `out_idx`  out  `IDX_WIDTH`  binary index of the held entry.

## Operation
- `load_en = ~out_vld | out_rdy`. The stage can accept a new entry when it is empty or is being drained in the same cycle.
- Priority pointer `ptr` (`IDX_WIDTH` bits) names the highest-priority requester. Search order is `ptr`, `ptr+1`, …, `WIDTH-1`, `0`, …, `ptr-1`.
- `grant` = one-hot of the first set bit of `v_req_vld` in search order, or zero if no request is set.
- `v_req_rdy = grant & {WIDTH{load_en}}`.
- A transfer on requester `i` occurs when `v_req_vld[i] & v_req_rdy[i]`. At most one transfer per cycle.
- On transfer:
  - `out_pld` ← mux(`grant`, `v_req_pld`).
  - `out_sel_onehot` ← `grant`.
  - `out_idx` ← `i`.
  - `out_vld` ← 1.
  - `ptr` ← `(i+1) mod WIDTH`, wrapping from `WIDTH-1` to 0. For non-power-of-2 `WIDTH`, use an explicit compare, not a bit truncation.
- When `out_vld & out_rdy` and there is no transfer: `out_vld` ← 0. The `out_pld`, `out_sel_onehot` and `out_idx` registers hold their last values.
- When `out_vld & ~out_rdy`: all output registers and `ptr` hold. `v_req_rdy` = 0.
- Drain and load in the same cycle: the new entry replaces the old one with no bubble and `out_vld` stays 1.
- `ptr` advances only on a transfer. Presenting requests while `load_en` = 0 does not move it.
- Requesters must keep `vld` and `pld` stable until accepted. The arbiter does not check this; grant may move to another requester while a non-granted one waits.

## Timing
- Reset values (asynchronous, as soon as `rst_n` = 0):
  - `out_vld` = 0.
  - `out_pld` = 0.
  - `out_sel_onehot` = 0.
  - `out_idx` = 0.
  - `ptr` = 0.
- `v_req_rdy` is combinational from `v_req_vld`, `ptr`, `out_vld` and `out_rdy`. There is a combinational path from `out_rdy` and `v_req_vld` to `v_req_rdy`. No combinational path exists to `out_*`.
- Latency: a request accepted in cycle N appears on `out_*` in cycle N+1.
- Throughput: 1 transfer per cycle when `out_rdy` = 1 continuously.
- Fairness: with all `WIDTH` requesters continuously valid and no back-pressure, each requester is granted exactly once in every `WIDTH` consecutive grants.
- Reset asserted mid-transfer: the held entry is discarded, `out_vld` = 0, and `ptr` returns to 0. The first grant after reset release goes to the lowest valid index.

## Test plan
- Reset, then only `v_req_vld[2]` = 1 with `pld` = 0xA5A5_0002 held 3 cycles, `out_rdy` = 1: `v_req_rdy` = 4'b0100 every cycle. `out_pld` = 0xA5A5_0002, `out_idx` = 2, `out_sel_onehot` = 4'b0100 from the next cycle. After the request drops, `out_vld` = 1 for one more cycle, then 0.
- All 4 requesters valid continuously, `out_rdy` = 1, 8 cycles after reset: `out_idx` sequence is 0,1,2,3,0,1,2,3 with `out_vld` = 1 every cycle after the first.
- `ptr` at 3 (last grant was idx 2), `v_req_vld` = 4'b0011: grant idx 0, then idx 1. Checks wrap-around.
- Entry held with `out_rdy` = 0 for 5 cycles while all requesters are valid: `v_req_rdy` = 0 throughout, and `out_pld`/`out_idx` are stable. When `out_rdy` = 1, in that same cycle the next requester is accepted and the output updates with no bubble.
- `rst_n` pulsed low asynchronously mid-cycle while `out_vld` = 1 and `ptr` = 2: outputs go to 0 immediately. After release with `v_req_vld` = 4'b1010, the first grant is idx 1.
- `WIDTH` = 3, `PLD_WIDTH` = 8, all requesters valid: `out_idx` cycles 0,1,2,0, and `ptr` never takes the value 3.
